// File: rtl/dsp_ar_order_ctrl_pkg.sv
// Shared interconnect definitions for the read-address order controller:
// slave-index decode and the default outstanding-burst depth.
package dsp_ar_order_ctrl_pkg;

    // Default number of read bursts that may be in flight at once.
    localparam int unsigned DEFAULT_OUTST_DEPTH = 4;

    // Handshake events seen by the order FIFO in one cycle.
    typedef struct packed {
        logic ar_push;
        logic r_pop;
    } order_evt_t;

    // Map the raw address-derived slave index onto a real slave.
    // Indices past the last slave are clamped onto the last slave.
    function automatic int unsigned decode_slv_id(
        input int unsigned raw,
        input int unsigned slv_amt
    );
        if (raw >= slv_amt) begin
            return slv_amt - 1;
        end
        return raw;
    endfunction

endpackage

// File: rtl/dsp_ar_order_ctrl_fifo.sv
// Order FIFO: stores slave indices of accepted read bursts in AR order.
// Callers must never push when full or pop when empty.
module dsp_ar_order_ctrl_fifo #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;

    // Storage write; contents need no reset since validity is tracked by cnt.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == CW'(FIFO_DEPTH));
    assign empty = (cnt == CW'(0));
    assign count = cnt;

endmodule

// File: rtl/dsp_ar_order_ctrl.sv
// Read-address order controller: routes master AR to the decoded slave and
// records the slave of every accepted burst so the RDATA dispatcher can
// follow bursts in issue order. Blocks AR while OUTST_DEPTH bursts are open.
// Optional build macro DSP_AR_OUTST_CNT_EN exposes the FIFO occupancy.
module dsp_ar_order_ctrl
    import dsp_ar_order_ctrl_pkg::*;
#(
    parameter int unsigned SLV_AMT     = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned SLV_ID_W    = $clog2(SLV_AMT),
    parameter int unsigned OUTST_DEPTH = DEFAULT_OUTST_DEPTH
) (
    input  logic                          ACLK_i,
    input  logic                          ARESETn_i,
    input  logic                          m_ARVALID_i,
    input  logic [ADDR_WIDTH-1:0]         m_ARADDR_i,
    output logic                          m_ARREADY_o,
    output logic [SLV_AMT-1:0]            sa_ARVALID_o,
    input  logic [SLV_AMT-1:0]            sa_ARREADY_i,
    input  logic                          m_RVALID_i,
    input  logic                          m_RREADY_i,
    input  logic                          m_RLAST_i,
    output logic [SLV_ID_W-1:0]           dsp_AR_slv_id_o,
    output logic                          dsp_AR_disable_o
`ifdef DSP_AR_OUTST_CNT_EN
    ,
    output logic [$clog2(OUTST_DEPTH):0]  m_outst_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(OUTST_DEPTH) + 1;

    logic [SLV_ID_W-1:0] raw_id;
    logic [SLV_ID_W-1:0] slv_id;
    logic                order_full;
    logic                order_empty;
    logic [SLV_ID_W-1:0] order_head;
    logic [CNT_W-1:0]    occupancy;
    order_evt_t          evt;
    logic                addr_unused;

    // Only the top address bits select the slave.
    assign raw_id      = m_ARADDR_i[ADDR_WIDTH-1 -: SLV_ID_W];
    assign slv_id      = SLV_ID_W'(decode_slv_id(32'(raw_id), SLV_AMT));
    assign addr_unused = ^m_ARADDR_i[ADDR_WIDTH-SLV_ID_W-1:0];

    // AR routing: one-hot valid to the selected slave, ready back to master.
    // Full is the registered FIFO flag, so a same-cycle pop does not unblock AR.
    // Both are forced low while reset is asserted.
    always_comb begin
        sa_ARVALID_o = '0;
        m_ARREADY_o  = 1'b0;
        if (ARESETn_i && !order_full) begin
            sa_ARVALID_o[slv_id] = m_ARVALID_i;
            m_ARREADY_o          = sa_ARREADY_i[slv_id];
        end
    end

    // FIFO events: push on AR handshake, pop on last R beat; pops while
    // empty are protocol errors and are dropped here.
    always_comb begin
        evt         = '0;
        evt.ar_push = m_ARVALID_i & m_ARREADY_o;
        evt.r_pop   = ARESETn_i & m_RVALID_i & m_RREADY_i & m_RLAST_i & ~order_empty;
    end

    dsp_ar_order_ctrl_fifo #(
        .DATA_WIDTH (SLV_ID_W),
        .FIFO_DEPTH (OUTST_DEPTH)
    ) u_order_fifo (
        .clk   (ACLK_i),
        .rst_n (ARESETn_i),
        .push  (evt.ar_push),
        .pop   (evt.r_pop),
        .wdata (slv_id),
        .rdata (order_head),
        .full  (order_full),
        .empty (order_empty),
        .count (occupancy)
    );

    // Head is masked when empty so the slave index reads 0 with nothing open.
    assign dsp_AR_slv_id_o  = order_empty ? '0 : order_head;
    assign dsp_AR_disable_o = order_empty;

`ifdef DSP_AR_OUTST_CNT_EN
    assign m_outst_cnt_o = occupancy;
`else
    logic occupancy_unused;
    assign occupancy_unused = ^occupancy;
`endif

endmodule
